// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: word width, reset/NOP constants and FSM states.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    // addi x0,x0,0
    localparam word_t NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} buffer: output slot presented downstream plus one skid slot.
module fetch_buffer #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [riscv_pkg::XLEN-1:0] push_pc,
    input  logic [riscv_pkg::XLEN-1:0] push_instr,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     out_valid,
    output logic [riscv_pkg::XLEN-1:0] out_pc,
    output logic [riscv_pkg::XLEN-1:0] out_instr,
    output logic                     skid_valid
);
    import riscv_pkg::*;

    fetch_pair_t out_q, skid_q, in_pair;
    logic        out_v, skid_v;

    assign in_pair = '{pc: push_pc, instr: push_instr};

    // Slot update: clear wins, then pop shifts skid forward, otherwise fill the first free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '{pc: RESET_PC, instr: '0};
            skid_q <= '0;
        end else if (clear) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (pop && skid_v) begin
            out_q  <= skid_q;
            out_v  <= 1'b1;
            skid_v <= push;
            if (push) skid_q <= in_pair;
        end else if (pop) begin
            out_v <= push;
            if (push) out_q <= in_pair;
        end else if (!out_v) begin
            if (push) begin
                out_v <= 1'b1;
                out_q <= in_pair;
            end
        end else if (push) begin
            // Requests are only issued with an empty skid, so this slot is free here.
            skid_v <= 1'b1;
            skid_q <= in_pair;
        end
    end

    assign out_valid  = out_v;
    assign out_pc     = out_q.pc;
    assign out_instr  = out_q.instr;
    assign skid_valid = skid_v;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs the imem req/gnt/rvalid
// handshake with one request in flight, and drops responses made stale by redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_if,
    output logic [31:0] Instruction_if,
    output logic        if_valid
);
    import riscv_pkg::*;

    fetch_state_e state_q;
    word_t        fetch_pc_q;
    word_t        redirect_tgt;
    logic         redir, resp, consume, granted;
    logic         out_valid, skid_valid;
    word_t        out_pc, out_instr;

    assign redirect_tgt = redirect_pc & ~32'd3;
    // Redirects are ignored during the single IDLE cycle after reset.
    assign redir    = redirect && (state_q != IDLE);
    assign resp     = (state_q == WAIT) && imem_rvalid && !redirect;
    assign consume  = EN && out_valid;
    assign imem_req = (state_q == REQ) && !skid_valid;
    assign granted  = imem_req && imem_gnt;
    assign imem_addr = fetch_pc_q;

    // Fetch FSM and fetch PC; a redirect overrides every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (redir) begin
                        fetch_pc_q <= redirect_tgt;
                        // A grant to the old address still owes us a response to drop.
                        state_q    <= granted ? DRAIN : REQ;
                    end else if (granted) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redir) begin
                        fetch_pc_q <= redirect_tgt;
                        state_q    <= imem_rvalid ? REQ : DRAIN;
                    end else if (imem_rvalid) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= REQ;
                    end
                end
                DRAIN: begin
                    if (redir) fetch_pc_q <= redirect_tgt;
                    if (imem_rvalid) state_q <= REQ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_buffer #(.RESET_PC(RESET_PC)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (resp),
        .push_pc    (fetch_pc_q),
        .push_instr (imem_rdata),
        .pop        (consume),
        .clear      (redir),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .skid_valid (skid_valid)
    );

    assign if_valid       = out_valid;
    assign PC_if          = out_pc;
    assign Instruction_if = out_valid ? out_instr : NOP_INSTR;

endmodule
